// File: rtl/wb_line_responder_pkg.sv
// rtl/wb_line_responder_pkg.sv - shared lc3b types: cache line and responder FSM state
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } wb_resp_state_t;

  localparam int LINE_BYTES = 16;

endpackage

// File: rtl/wb_line_responder_if.sv
// rtl/wb_line_responder_if.sv - line-wide wishbone interface with master/slave ends
interface wishbone;
  import lc3b_types::*;

  logic       CYC;
  logic       STB;
  logic       WE;
  logic [11:0] ADR;
  logic [15:0] SEL;
  lc3b_line   DAT_M;
  lc3b_line   DAT_S;
  logic       ACK;

  modport master (
    output CYC, STB, WE, ADR, SEL, DAT_M,
    input  DAT_S, ACK
  );

  modport slave (
    input  CYC, STB, WE, ADR, SEL, DAT_M,
    output DAT_S, ACK
  );

endinterface

// File: rtl/wb_line_responder_byte_merge.sv
// rtl/wb_line_responder_byte_merge.sv - byte-enable merge of a new line over an old line
module wb_byte_merge
  import lc3b_types::*;
(
  input  lc3b_line    old_line,
  input  lc3b_line    new_line,
  input  logic [15:0] sel,
  output lc3b_line    merged
);

  always_comb begin
    merged = old_line;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (sel[i]) begin
        merged[8*i +: 8] = new_line[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_line_responder.sv
// rtl/wb_line_responder.sv - fixed-latency wishbone line store; WB_RESP_STATS_EN adds rd/wr counters
module wb_line_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wishbone.slave      wb
`ifdef WB_RESP_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  wb_resp_state_t         state;
  wb_resp_state_t         next_state;
  logic [3:0]             cnt;
  logic [3:0]             cnt_next;
  logic [DEPTH_LOG2-1:0]  adr_q;
  logic                   we_q;
  logic [15:0]            sel_q;
  lc3b_line               dat_q;
  lc3b_line               dat_s;
  lc3b_line               merged;
  logic [DEPTH_LOG2-1:0]  rd_idx;
  logic                   req;
  logic                   sample;
  logic                   resp_entry;
  logic                   ack;
  logic                   mem_we;
  logic                   unused_adr;

  lc3b_line mem [0:(2**DEPTH_LOG2)-1];

  assign req        = wb.CYC & wb.STB;
  assign sample     = (state == IDLE) & req;
  assign resp_entry = (next_state == RESP) & (state != RESP);
  assign ack        = (state == RESP) & req;
  assign mem_we     = ack & we_q & (|sel_q);
  assign unused_adr = &{1'b0, wb.ADR};

  // With LATENCY==1 RESP is entered straight from IDLE, before adr_q holds the request.
  assign rd_idx = (state == IDLE) ? wb.ADR[DEPTH_LOG2-1:0] : adr_q;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          next_state = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      dat_s <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (sample) begin
        adr_q <= wb.ADR[DEPTH_LOG2-1:0];
        we_q  <= wb.WE;
        sel_q <= wb.SEL;
        dat_q <= wb.DAT_M;
      end
      if (resp_entry) begin
        dat_s <= mem[rd_idx];
      end
    end
  end

  // dat_s still holds the pre-write line during RESP, so it doubles as the merge source.
  wb_byte_merge u_merge (
    .old_line (dat_s),
    .new_line (dat_q),
    .sel      (sel_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[adr_q] <= merged;
    end
  end

  assign wb.DAT_S = dat_s;
  assign wb.ACK   = ack;

`ifdef WB_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (ack) begin
      if (we_q) begin
        wr_count <= wr_count + 16'd1;
      end else begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_line_responder.sv
// tb/tb_wb_line_responder.sv - directed self-checking bench for wb_line_responder
`timescale 1ns/1ps
module tb_wb_line_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  wishbone bus ();
  wishbone bus1 ();

  // Second responder with LATENCY=1 sees the same requests.
  assign bus1.CYC   = bus.CYC;
  assign bus1.STB   = bus.STB;
  assign bus1.WE    = bus.WE;
  assign bus1.ADR   = bus.ADR;
  assign bus1.SEL   = bus.SEL;
  assign bus1.DAT_M = bus.DAT_M;

`ifdef WB_RESP_STATS_EN
  logic [15:0] rd_count, wr_count, rd_count1, wr_count1;
`endif

  wb_line_responder #(.LATENCY(3), .DEPTH_LOG2(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
`ifdef WB_RESP_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  wb_line_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus1)
`ifdef WB_RESP_STATS_EN
    ,
    .rd_count (rd_count1),
    .wr_count (wr_count1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  lc3b_line ack1_data;
  logic     ack1_first;

  task automatic xfer(input logic [11:0] a, input logic w, input logic [15:0] s,
                      input lc3b_line d, output lc3b_line q, output int lat);
    @(negedge clk);
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = w; bus.ADR = a; bus.SEL = s; bus.DAT_M = d;
    lat = 0;
    q = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ack1_first = bus1.ACK;
        ack1_data  = bus1.DAT_S;
      end
      if (bus.ACK) begin
        lat = k;
        q = bus.DAT_S;
        break;
      end
    end
    @(posedge clk); #1;
    check_eq("ack_one_cycle", {127'd0, bus.ACK}, 128'd0);
    bus.CYC = 1'b0; bus.STB = 1'b0;
  endtask

  lc3b_line q;
  int       lat;
  int       t [3];
  lc3b_line mrg;
  int       acks;

  initial begin
    bus.CYC = 0; bus.STB = 0; bus.WE = 0; bus.ADR = '0; bus.SEL = '0; bus.DAT_M = '0;
    mrg = {{14{8'hFF}}, 16'h1234};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {127'd0, bus.ACK}, 128'd0);
    check_eq("rst_dat_s", bus.DAT_S, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read at LATENCY 3, plus LATENCY 1 on dut1.
    xfer(12'h005, 1'b1, 16'hFFFF, {16{8'hA5}}, q, lat);
    check_eq("wr5_lat", 128'(lat), 128'd3);
    xfer(12'h005, 1'b0, 16'h0000, '0, q, lat);
    check_eq("rd5_lat", 128'(lat), 128'd3);
    check_eq("rd5_data", q, {16{8'hA5}});
    check_eq("l1_ack", {127'd0, ack1_first}, 128'd1);
    check_eq("l1_data", ack1_data, {16{8'hA5}});
    xfer(12'h105, 1'b0, 16'h0000, '0, q, lat);
    check_eq("rd105_upper_ignored", q, {16{8'hA5}});

    // Byte merge, pre-write DAT_S, SEL==0 write.
    xfer(12'h010, 1'b1, 16'hFFFF, {16{8'hFF}}, q, lat);
    xfer(12'h010, 1'b1, 16'h0003, 128'h1234, q, lat);
    check_eq("wr10_prewrite", q, {16{8'hFF}});
    xfer(12'h010, 1'b0, 16'h0000, '0, q, lat);
    check_eq("rd10_merged", q, mrg);
    check_eq("l1_rd10_merged", ack1_data, mrg);
    xfer(12'h010, 1'b1, 16'h0000, 128'd0, q, lat);
    check_eq("sel0_lat", 128'(lat), 128'd3);
    xfer(12'h010, 1'b0, 16'h0000, '0, q, lat);
    check_eq("sel0_nochange", q, mrg);

    // Back-to-back reads with STB held.
    for (int i = 0; i < 3; i++) begin
      xfer(12'(i), 1'b1, 16'hFFFF, {16{8'(8'h10 + i)}}, q, lat);
    end
    @(negedge clk);
    bus.CYC = 1; bus.STB = 1; bus.WE = 0; bus.ADR = 12'h000; bus.SEL = 16'h0;
    for (int i = 0; i < 3; i++) begin
      t[i] = -1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (bus.ACK) begin
          t[i] = cyc;
          check_eq($sformatf("b2b_data%0d", i), bus.DAT_S, {16{8'(8'h10 + i)}});
          bus.ADR = 12'(i + 1);
          break;
        end
      end
    end
    @(posedge clk); #1;
    bus.CYC = 0; bus.STB = 0;
    check_eq("b2b_gap01", 128'(t[1] - t[0]), 128'd4);
    check_eq("b2b_gap12", 128'(t[2] - t[1]), 128'd4);

    // Abort mid-BUSY.
    xfer(12'h020, 1'b1, 16'hFFFF, {16{8'h5A}}, q, lat);
    @(negedge clk);
    bus.CYC = 1; bus.STB = 1; bus.WE = 1; bus.ADR = 12'h020; bus.SEL = 16'hFFFF; bus.DAT_M = '0;
    @(posedge clk); @(posedge clk); #1;
    bus.CYC = 0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.ACK) acks++;
    end
    bus.STB = 0;
    check_eq("abort_no_ack", 128'(acks), 128'd0);
    xfer(12'h020, 1'b0, 16'h0000, '0, q, lat);
    check_eq("abort_old_data", q, {16{8'h5A}});

    // Reset while in RESP drops the write.
    xfer(12'h030, 1'b1, 16'hFFFF, {16{8'h33}}, q, lat);
    @(negedge clk);
    bus.CYC = 1; bus.STB = 1; bus.WE = 1; bus.ADR = 12'h030; bus.SEL = 16'hFFFF; bus.DAT_M = {16{8'hCC}};
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.ACK) begin
        acks = 1;
        break;
      end
    end
    check_eq("resp_reached", 128'(acks), 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_resp_ack", {127'd0, bus.ACK}, 128'd0);
    check_eq("rst_resp_dat_s", bus.DAT_S, 128'd0);
`ifdef WB_RESP_STATS_EN
    check_eq("rst_rd_count", 128'(rd_count), 128'd0);
    check_eq("rst_wr_count", 128'(wr_count), 128'd0);
`endif
    @(negedge clk);
    bus.CYC = 0; bus.STB = 0;
    rst_n = 1'b1;
    xfer(12'h030, 1'b0, 16'h0000, '0, q, lat);
    check_eq("rst_no_write", q, {16{8'h33}});
`ifdef WB_RESP_STATS_EN
    check_eq("rd_count_one", 128'(rd_count), 128'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
